// File: rtl/cook_sequencer_if.sv
// Control/status bundle between the microwave front panel and the cook sequencer.
// The panel side drives the requests; the sequencer side drives the time, state and magnetron outputs.
interface cook_sequencer_if;
    logic        tick_1hz;
    logic        start_pulse;
    logic        stop_pulse;
    logic        clear_pulse;
    logic        door_closed;
    logic        load_en;
    logic [15:0] load_time;
    logic [3:0]  load_power;
    logic [15:0] time_left;
    logic [1:0]  state;
    logic        mag_on;
    logic        timer_done;
    logic        beep;

    modport master (
        output tick_1hz, start_pulse, stop_pulse, clear_pulse, door_closed,
               load_en, load_time, load_power,
        input  time_left, state, mag_on, timer_done, beep
    );

    modport slave (
        input  tick_1hz, start_pulse, stop_pulse, clear_pulse, door_closed,
               load_en, load_time, load_power,
        output time_left, state, mag_on, timer_done, beep
    );
endinterface

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: BCD mm:ss countdown on a 1 Hz tick and power-level duty cycling of the magnetron.
// Optional done beeper enabled by defining MICROWAVE_DONE_BEEP_EN.
module cook_sequencer #(
    parameter int DUTY_WINDOW = 10,
    parameter int BEEP_TICKS  = 3
) (
    input logic              clk,
    input logic              rst,
    cook_sequencer_if.slave  bus
);

    localparam int DW = (DUTY_WINDOW > 1) ? $clog2(DUTY_WINDOW) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    if (DUTY_WINDOW < 2 || BEEP_TICKS < 1) begin : g_bad_params
        $error("cook_sequencer: DUTY_WINDOW must be >= 2 and BEEP_TICKS >= 1");
    end

    state_e        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [3:0]    power_q, power_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          load_ok;

    // Decrement mm:ss in BCD; seconds tens borrow to 5, everything else to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t != 16'h0000) begin
            if (t[3:0] != 4'd0) begin
                r[3:0] = t[3:0] - 4'd1;
            end else begin
                r[3:0] = 4'd9;
                if (t[7:4] != 4'd0) begin
                    r[7:4] = t[7:4] - 4'd1;
                end else begin
                    r[7:4] = 4'd5;
                    if (t[11:8] != 4'd0) begin
                        r[11:8] = t[11:8] - 4'd1;
                    end else begin
                        r[11:8]  = 4'd9;
                        r[15:12] = t[15:12] - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    assign load_ok = bus.load_en
                   && (bus.load_time[15:12] <= 4'd9) && (bus.load_time[11:8] <= 4'd9)
                   && (bus.load_time[7:4]   <= 4'd5) && (bus.load_time[3:0]  <= 4'd9)
                   && (bus.load_power >= 4'd1) && (bus.load_power <= 4'd10);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            time_q  <= 16'h0000;
            power_q <= 4'd10;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            power_q <= power_d;
            duty_q  <= duty_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        power_d = power_q;
        duty_d  = duty_q;
        if (bus.clear_pulse) begin
            state_d = IDLE;
            time_d  = 16'h0000;
            power_d = 4'd10;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_pulse && bus.door_closed && (time_q != 16'h0000)) begin
                        state_d = COOK;
                        duty_d  = '0;
                    end else if (load_ok) begin
                        time_d  = bus.load_time;
                        power_d = bus.load_power;
                    end
                end
                COOK: begin
                    if (!bus.door_closed || bus.stop_pulse) begin
                        state_d = PAUSED;
                    end else if (bus.tick_1hz) begin
                        time_d = bcd_dec(time_q);
                        duty_d = (duty_q == DW'(DUTY_WINDOW - 1)) ? '0 : duty_q + 1'b1;
                        if (time_q == 16'h0001) state_d = DONE;
                    end
                end
                PAUSED: begin
                    if (bus.stop_pulse) begin
                        state_d = IDLE;
                        time_d  = 16'h0000;
                    end else if (bus.start_pulse && bus.door_closed) begin
                        state_d = COOK;
                    end
                end
                DONE: begin
                    if (!bus.door_closed || bus.stop_pulse || bus.start_pulse) begin
                        state_d = IDLE;
                    end else if (load_ok) begin
                        state_d = IDLE;
                        time_d  = bus.load_time;
                        power_d = bus.load_power;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Door gates combinationally so opening it kills the magnetron within the same cycle.
    assign bus.mag_on     = (state_q == COOK) && bus.door_closed
                          && (32'(duty_q) < 32'(power_q));
    assign bus.time_left  = time_q;
    assign bus.state      = state_q;
    assign bus.timer_done = (state_q == DONE);

`ifdef MICROWAVE_DONE_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);

    logic          beep_q, beep_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    // Beep starts on DONE entry and counts ticks while DONE is held; any exit drops it.
    always_comb begin
        beep_d     = 1'b0;
        beep_cnt_d = beep_cnt_q;
        if (state_d == DONE) begin
            if (state_q != DONE) begin
                beep_d     = 1'b1;
                beep_cnt_d = '0;
            end else if (beep_q && bus.tick_1hz) begin
                if (beep_cnt_q == BW'(BEEP_TICKS - 1)) begin
                    beep_d = 1'b0;
                end else begin
                    beep_d     = 1'b1;
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end else begin
                beep_d = beep_q;
            end
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer: load/start/tick sequences with hand-computed time, state and mag_on.
// Beep expectations follow MICROWAVE_DONE_BEEP_EN.
module tb_cook_sequencer;

`ifdef MICROWAVE_DONE_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    localparam logic [15:0] S_IDLE   = 16'd0;
    localparam logic [15:0] S_COOK   = 16'd1;
    localparam logic [15:0] S_PAUSED = 16'd2;
    localparam logic [15:0] S_DONE   = 16'd3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   highs;

    cook_sequencer_if bus ();

    cook_sequencer #(.DUTY_WINDOW(10), .BEEP_TICKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick_1hz = 1'b1;
        cycle();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic do_start();
        bus.start_pulse = 1'b1;
        cycle();
        bus.start_pulse = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop_pulse = 1'b1;
        cycle();
        bus.stop_pulse = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] t, input logic [3:0] p);
        bus.load_en    = 1'b1;
        bus.load_time  = t;
        bus.load_power = p;
        cycle();
        bus.load_en    = 1'b0;
    endtask

    function automatic logic [15:0] secs_bcd(input int s);
        return {8'h00, 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_time"}, bus.time_left, 16'h0000);
        check({tag, "_state"}, 16'(bus.state), S_IDLE);
        check({tag, "_mag"}, 16'(bus.mag_on), 16'd0);
        check({tag, "_done"}, 16'(bus.timer_done), 16'd0);
        check({tag, "_beep"}, 16'(bus.beep), 16'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        highs  = 0;
        rst             = 1'b1;
        bus.tick_1hz    = 1'b0;
        bus.start_pulse = 1'b0;
        bus.stop_pulse  = 1'b0;
        bus.clear_pulse = 1'b0;
        bus.door_closed = 1'b1;
        bus.load_en     = 1'b0;
        bus.load_time   = 16'h0000;
        bus.load_power  = 4'd0;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Start with time 00:00 is ignored.
        do_start();
        check("start_zero_state", 16'(bus.state), S_IDLE);
        check("start_zero_mag", 16'(bus.mag_on), 16'd0);

        // 00:05 at full power.
        do_load(16'h0005, 4'd10);
        check("load5_time", bus.time_left, 16'h0005);
        do_start();
        check("cook5_state", 16'(bus.state), S_COOK);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cook5_mag%0d", i), 16'(bus.mag_on), 16'd1);
            do_tick();
            check($sformatf("cook5_time%0d", i), bus.time_left, secs_bcd(4 - i));
        end
        check("cook5_state_done", 16'(bus.state), S_DONE);
        check("cook5_timer_done", 16'(bus.timer_done), 16'd1);
        check("cook5_mag_done", 16'(bus.mag_on), 16'd0);

        // Beep on DONE entry, held for three ticks when the feature is built.
        check("beep_t0", 16'(bus.beep), 16'(BEEP_ON));
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check($sformatf("beep_t%0d", k), 16'(bus.beep), 16'(BEEP_ON && (k < 3)));
            check($sformatf("done_hold%0d", k), 16'(bus.state), S_DONE);
        end

        // Valid load in DONE returns to IDLE; 00:20 at power 3.
        do_load(16'h0020, 4'd3);
        check("load20_state", 16'(bus.state), S_IDLE);
        check("load20_time", bus.time_left, 16'h0020);
        do_start();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("p3_mag%0d", k), 16'(bus.mag_on), 16'((k % 10) < 3));
            if (bus.mag_on) highs++;
            do_tick();
            check($sformatf("p3_time%0d", k), bus.time_left, secs_bcd(19 - k));
        end
        check("p3_highs", 16'(highs), 16'd6);
        check("p3_state_done", 16'(bus.state), S_DONE);

        do_stop();
        check("done_stop_state", 16'(bus.state), S_IDLE);

        // Door open mid-cook: immediate mag_on drop, then PAUSED and frozen.
        do_load(16'h0100, 4'd10);
        do_start();
        do_tick();
        check("door_time59", bus.time_left, 16'h0059);
        bus.door_closed = 1'b0;
        #1;
        check("door_mag_same_cycle", 16'(bus.mag_on), 16'd0);
        check("door_state_same_cycle", 16'(bus.state), S_COOK);
        cycle();
        check("door_paused", 16'(bus.state), S_PAUSED);
        do_tick();
        do_tick();
        check("paused_time_frozen", bus.time_left, 16'h0059);
        bus.door_closed = 1'b1;
        do_start();
        check("resume_state", 16'(bus.state), S_COOK);
        check("resume_mag", 16'(bus.mag_on), 16'd1);
        do_tick();
        check("resume_time58", bus.time_left, 16'h0058);

        // stop + tick in COOK: paused, tick discarded.
        bus.stop_pulse = 1'b1;
        bus.tick_1hz   = 1'b1;
        cycle();
        bus.stop_pulse = 1'b0;
        bus.tick_1hz   = 1'b0;
        check("stop_tick_state", 16'(bus.state), S_PAUSED);
        check("stop_tick_time", bus.time_left, 16'h0058);

        // clear + start + tick in COOK: clear wins.
        do_start();
        bus.clear_pulse = 1'b1;
        bus.start_pulse = 1'b1;
        bus.tick_1hz    = 1'b1;
        cycle();
        bus.clear_pulse = 1'b0;
        bus.start_pulse = 1'b0;
        bus.tick_1hz    = 1'b0;
        check("clear_state", 16'(bus.state), S_IDLE);
        check("clear_time", bus.time_left, 16'h0000);
        check("clear_mag", 16'(bus.mag_on), 16'd0);

        // Invalid loads leave time and power untouched.
        do_load(16'h0032, 4'd2);
        check("load32_time", bus.time_left, 16'h0032);
        do_load(16'h0075, 4'd5);
        check("bad_sec_tens", bus.time_left, 16'h0032);
        do_load(16'h0A00, 4'd5);
        check("bad_min_ones", bus.time_left, 16'h0032);
        do_load(16'h0040, 4'd0);
        check("bad_power0", bus.time_left, 16'h0032);
        do_load(16'h0040, 4'd11);
        check("bad_power11", bus.time_left, 16'h0032);

        // Power 2 retained: mag_on for duty 0 and 1 only.
        do_start();
        check("p2_mag0", 16'(bus.mag_on), 16'd1);
        do_tick();
        check("p2_mag1", 16'(bus.mag_on), 16'd1);
        check("p2_time31", bus.time_left, 16'h0031);
        do_tick();
        check("p2_mag2", 16'(bus.mag_on), 16'd0);
        check("p2_time30", bus.time_left, 16'h0030);
        do_load(16'h0010, 4'd10);
        check("cook_load_ignored_time", bus.time_left, 16'h0030);
        check("cook_load_ignored_mag", 16'(bus.mag_on), 16'd0);

        // Reset mid-cook at 00:30.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs("midcook_rst");

        // Stop in PAUSED clears time to 00:00.
        do_load(16'h0012, 4'd1);
        do_start();
        do_stop();
        check("pause_by_stop", 16'(bus.state), S_PAUSED);
        do_stop();
        check("paused_stop_state", 16'(bus.state), S_IDLE);
        check("paused_stop_time", bus.time_left, 16'h0000);

        // Door opening in DONE returns to IDLE.
        do_load(16'h0001, 4'd1);
        do_start();
        do_tick();
        check("one_sec_done", 16'(bus.state), S_DONE);
        bus.door_closed = 1'b0;
        cycle();
        check("done_door_state", 16'(bus.state), S_IDLE);
        check("done_door_beep", 16'(bus.beep), 16'd0);
        bus.door_closed = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
Cook sequencer for the microwave. It holds the programmed cook time (BCD mm:ss) and power level, runs the countdown on a 1 Hz tick and duty-cycles the magnetron enable according to power level. It sits above the magnetron on/off control. It produces the mag_on request and the timer_done indication consumed by the magnetron control path and the display/beeper.

Parameters:
DUTY_WINDOW, 10, length of the power duty window in ticks; power level N enables the magnetron for N of every DUTY_WINDOW ticks
BEEP_TICKS, 3, number of ticks beep stays high after DONE; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_1hz  in  1  single-cycle enable, once per second
start_pulse  in  1  single-cycle start request
stop_pulse  in  1  single-cycle stop/pause request
clear_pulse  in  1  single-cycle clear request
door_closed  in  1  1 = door closed
load_en  in  1  single-cycle load of time and power
load_time  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
load_power  in  4  power level, valid range 1..10
time_left  out  16  current BCD mm:ss
state  out  2  0 IDLE, 1 COOK, 2 PAUSED, 3 DONE
mag_on  out  1  magnetron enable request
timer_done  out  1  high while in DONE
beep  out  1  done beeper; only with optional feature, otherwise tied 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset applies at the next clk edge, including mid-cook.
- Reset values: state=IDLE, time_left=16'h0000, power=10, duty counter=0, mag_on=0, timer_done=0, beep=0.
- Event priority within one cycle: clear > door open > stop > start > load > tick. Only the highest-priority applicable event acts.
- Load (IDLE or DONE only):
  - Stores load_time and load_power only if every BCD digit ≤9, sec_tens ≤5, and 1 ≤ load_power ≤ 10.
  - Otherwise the whole load is ignored and stored values are unchanged.
  - A valid load in DONE moves the block to IDLE.
  - Loads in COOK or PAUSED are ignored.
- IDLE:
  - start_pulse with door_closed=1 and time_left≠0 → COOK on the next cycle.
  - Start with time_left=0 or the door open is ignored.
  - Entering COOK from IDLE resets the duty counter to 0.
- COOK:
  - On tick_1hz, time_left decrements in BCD: ss ones, then ss tens (00 borrows to 59), then minutes. Range 00:00..99:59, no wrap below 00:00.
  - On each tick the duty counter increments, wrapping at DUTY_WINDOW-1 → 0.
  - Tick that takes time_left from 00:01 to 00:00 → DONE.
  - stop_pulse → PAUSED.
  - door_closed=0 → PAUSED.
  - A tick coinciding with stop, door open or clear is not counted.
- PAUSED:
  - time_left and the duty counter are frozen.
  - start_pulse with door_closed=1 → COOK, counters resumed unchanged.
  - stop_pulse → IDLE with time_left cleared to 00:00; power is retained.
- DONE:
  - timer_done=1; time_left=00:00.
  - start_pulse, stop_pulse or door opening → IDLE.
- clear_pulse, any state: → IDLE, time_left=00:00, power=10, duty counter=0.
- mag_on = (state==COOK) & door_closed & (duty_cnt < power):
  - state, duty_cnt and power are registered; door_closed gates combinationally, so opening the door drops mag_on in the same cycle.
  - mag_on is 0 in all non-COOK states.
- The registered first COOK cycle after start asserts mag_on when duty_cnt=0 < power.

Optional Feature:
- Macro: MICROWAVE_DONE_BEEP_EN.
- Defined: beep goes high on the cycle the block enters DONE and stays high for BEEP_TICKS tick_1hz pulses. Leaving DONE before then (start, stop, clear, door open, or valid load) drops beep the next cycle.
- Undefined: no beep counter is built and beep is constant 0.

Test Plan:
- Reset, load 00:05 power 10, start with door closed → COOK next cycle; mag_on=1 for all 5 ticks; time_left 00:04..00:00; DONE with timer_done=1 after the 5th tick.
- Load 00:20 power 3, start, 20 ticks → mag_on high during ticks 0-2 and 10-12 of each window, low otherwise (6 of 20 seconds); ends in DONE.
- Load 01:00, start, after 1 tick (00:59) drop door_closed → mag_on=0 same cycle, PAUSED next cycle; extra ticks leave 00:59; close door + start → COOK resumes, next tick gives 00:58.
- Invalid loads: load 00:75 or power 0 or power 11 → time_left and power unchanged. Start with time_left=00:00 → stays IDLE, mag_on=0.
- Same cycle in COOK: clear_pulse+start_pulse+tick → IDLE, 00:00, mag_on=0. stop_pulse+tick → PAUSED with time unchanged.
- rst asserted mid-COOK at 00:30 → next edge all outputs at reset values. With MICROWAVE_DONE_BEEP_EN, DONE asserts beep for exactly 3 ticks.
